// File: rtl/rpll_ctrl.sv
// rpll_ctrl: Gowin rPLL power-up sequencer and PSDA/DUTYDA dynamic-config controller.
// Runs on the crystal clock. It pulses the PLL reset, waits for a stable lock and then
// releases the downstream reset. A lost lock re-runs the sequence. Phase and duty updates
// are serialised, and the downstream reset is held while the clock settles.
// Ports:
//   sys_clk, reset (sync, active-high) - crystal clock and block reset
//   pll_lock                           - rPLL LOCK (async, synchronised internally)
//   pll_reset, pll_reset_p             - rPLL RESET / RESET_P (identical)
//   psda, dutyda                       - rPLL phase / duty dynamic settings
//   cfg_valid/cfg_ready/cfg_psda/cfg_dutyda - config request handshake
//   sys_rst_out, locked                - downstream reset and RUN indicator
//   loss_cnt                           - lock-loss event counter
// Optional feature: define RPLL_CTRL_LOSS_CNT_EN to enable the saturating loss_cnt.
// When it is undefined, loss_cnt is tied to zero.
module rpll_ctrl #(
    parameter int         RST_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         STABLE_CYCLES = 1024,
    parameter int         SETTLE_CYCLES = 64,
    parameter int         CNT_W         = 20,
    parameter logic [3:0] PSDA_INIT     = 4'b0000,
    parameter logic [3:0] DUTYDA_INIT   = 4'b1000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       pll_reset_p,
    output logic [3:0] psda,
    output logic [3:0] dutyda,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    output logic       sys_rst_out,
    output logic       locked,
    output logic [7:0] loss_cnt
);

    localparam logic [CNT_W-1:0] C_RST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LOCK   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_SETTLE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic             r_pll_reset;
    logic             r_sys_rst;
    logic             r_locked;
    logic             r_cfg_ready;
    logic [3:0]       r_psda;
    logic [3:0]       r_dutyda;

    logic w_cnt_zero;
    logic w_live;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_live     = (r_state == S_RUN) || (r_state == S_SETTLE);

    // LOCK is ignored while the PLL is held in reset: the synchroniser is
    // flushed so a stale lock from before the reset pulse is never counted.
    always_ff @(posedge sys_clk) begin
        if (reset || r_state == S_PLL_RST) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= C_RST;
            r_pll_reset <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_psda      <= PSDA_INIT;
            r_dutyda    <= DUTYDA_INIT;
        end else if (w_live && !r_lock_s) begin
            // Lock loss takes priority over any pending config accept.
            r_state     <= S_PLL_RST;
            r_cnt       <= C_RST;
            r_pll_reset <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b0;
        end else begin
            case (r_state)
                S_PLL_RST: begin
                    if (w_cnt_zero) begin
                        r_state     <= S_WAIT_LOCK;
                        r_cnt       <= C_LOCK;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= C_STABLE;
                    end else if (w_cnt_zero) begin
                        r_state     <= S_PLL_RST;
                        r_cnt       <= C_RST;
                        r_pll_reset <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!r_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= C_LOCK;
                    end else if (w_cnt_zero) begin
                        r_state     <= S_RUN;
                        r_sys_rst   <= 1'b0;
                        r_locked    <= 1'b1;
                        r_cfg_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (cfg_valid && r_cfg_ready) begin
                        r_psda      <= cfg_psda;
                        r_dutyda    <= cfg_dutyda;
                        r_state     <= S_SETTLE;
                        r_cnt       <= C_SETTLE;
                        r_sys_rst   <= 1'b1;
                        r_locked    <= 1'b0;
                        r_cfg_ready <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (w_cnt_zero) begin
                        r_state     <= S_RUN;
                        r_sys_rst   <= 1'b0;
                        r_locked    <= 1'b1;
                        r_cfg_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= S_PLL_RST;
                    r_cnt       <= C_RST;
                    r_pll_reset <= 1'b1;
                    r_sys_rst   <= 1'b1;
                    r_locked    <= 1'b0;
                    r_cfg_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef RPLL_CTRL_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_loss_cnt <= 8'h00;
        end else if (w_live && !r_lock_s && r_loss_cnt != 8'hFF) begin
            r_loss_cnt <= r_loss_cnt + 8'h01;
        end
    end

    assign loss_cnt = r_loss_cnt;
`else
    assign loss_cnt = 8'h00;
`endif

    assign pll_reset   = r_pll_reset;
    assign pll_reset_p = r_pll_reset;
    assign psda        = r_psda;
    assign dutyda      = r_dutyda;
    assign cfg_ready   = r_cfg_ready;
    assign sys_rst_out = r_sys_rst;
    assign locked      = r_locked;

endmodule

// File: tb/tb_rpll_ctrl.sv
// tb_rpll_ctrl: directed bench for rpll_ctrl (RST=4, TIMEOUT=20, STABLE=8, SETTLE=5).
// Release latency with lock stable is 15 edges: 4 in PLL_RST, 2 sync, 1 into STABLE, 8 counting.
module tb_rpll_ctrl;

`ifdef RPLL_CTRL_LOSS_CNT_EN
    localparam int LOSS_ON = 1;
`else
    localparam int LOSS_ON = 0;
`endif

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic       pll_reset_p;
    logic [3:0] psda;
    logic [3:0] dutyda;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_psda;
    logic [3:0] cfg_dutyda;
    logic       sys_rst_out;
    logic       locked;
    logic [7:0] loss_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    rpll_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .SETTLE_CYCLES(5)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_reset_p(pll_reset_p),
        .psda       (psda),
        .dutyda     (dutyda),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_psda   (cfg_psda),
        .cfg_dutyda (cfg_dutyda),
        .sys_rst_out(sys_rst_out),
        .locked     (locked),
        .loss_cnt   (loss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (sys_rst_out && n < 300) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, locked}, 32'd1);
    endtask

    task automatic drop_lock(input string tag);
        pll_lock = 1'b0;
        tick();
        tick();
        chk({tag, "_pre"}, {31'd0, sys_rst_out}, 32'd0);
        tick();
        chk({tag, "_rst"}, {31'd0, sys_rst_out}, 32'd1);
        chk({tag, "_pll"}, {31'd0, pll_reset}, 32'd1);
        chk({tag, "_lkd"}, {31'd0, locked}, 32'd0);
        chk({tag, "_ps"}, {28'd0, psda}, 32'h3);
        chk({tag, "_du"}, {28'd0, dutyda}, 32'h6);
        pll_lock = 1'b1;
    endtask

    initial begin
        int n;
        logic seen_low;
        reset      = 1'b1;
        pll_lock   = 1'b1;
        cfg_valid  = 1'b0;
        cfg_psda   = 4'h0;
        cfg_dutyda = 4'h0;
        repeat (3) tick();

        chk("rst_pll", {31'd0, pll_reset}, 32'd1);
        chk("rst_pllp", {31'd0, pll_reset_p}, 32'd1);
        chk("rst_sys", {31'd0, sys_rst_out}, 32'd1);
        chk("rst_lkd", {31'd0, locked}, 32'd0);
        chk("rst_rdy", {31'd0, cfg_ready}, 32'd0);
        chk("rst_ps", {28'd0, psda}, 32'h0);
        chk("rst_du", {28'd0, dutyda}, 32'h8);
        chk("rst_loss", {24'd0, loss_cnt}, 32'h0);

        // Test 1: power-up with lock constantly high
        reset = 1'b0;
        repeat (3) tick();
        chk("t1_pll3", {31'd0, pll_reset}, 32'd1);
        tick();
        chk("t1_pll4", {31'd0, pll_reset}, 32'd0);
        n = 4;
        while (sys_rst_out && n < 100) begin
            tick();
            n++;
        end
        chk("t1_lat", n, 32'd15);
        chk("t1_lkd", {31'd0, locked}, 32'd1);
        chk("t1_rdy", {31'd0, cfg_ready}, 32'd1);
        chk("t1_ps", {28'd0, psda}, 32'h0);
        chk("t1_du", {28'd0, dutyda}, 32'h8);

        // Test 4: config update in RUN
        cfg_valid  = 1'b1;
        cfg_psda   = 4'h3;
        cfg_dutyda = 4'h6;
        tick();
        cfg_valid = 1'b0;
        chk("t4_ps", {28'd0, psda}, 32'h3);
        chk("t4_du", {28'd0, dutyda}, 32'h6);
        chk("t4_rdy", {31'd0, cfg_ready}, 32'd0);
        chk("t4_lkd", {31'd0, locked}, 32'd0);
        chk("t4_sys0", {31'd0, sys_rst_out}, 32'd1);
        repeat (4) tick();
        chk("t4_sys4", {31'd0, sys_rst_out}, 32'd1);
        tick();
        chk("t4_sys5", {31'd0, sys_rst_out}, 32'd0);
        chk("t4_run", {31'd0, locked}, 32'd1);

        // Test 5: two lock losses in RUN
        drop_lock("t5a");
        wait_run("t5a_relock");
        drop_lock("t5b");
        wait_run("t5b_relock");
        chk("t5_loss", {24'd0, loss_cnt}, 32'(2 * LOSS_ON));

        // Test 6: lock loss coincides with a config accept
        pll_lock = 1'b0;
        tick();
        tick();
        cfg_valid  = 1'b1;
        cfg_psda   = 4'hA;
        cfg_dutyda = 4'h2;
        chk("t6_rdy", {31'd0, cfg_ready}, 32'd1);
        tick();
        cfg_valid = 1'b0;
        chk("t6_pll", {31'd0, pll_reset}, 32'd1);
        chk("t6_ps", {28'd0, psda}, 32'h3);
        chk("t6_du", {28'd0, dutyda}, 32'h6);
        chk("t6_sys", {31'd0, sys_rst_out}, 32'd1);
        chk("t6_loss", {24'd0, loss_cnt}, 32'(3 * LOSS_ON));
        pll_lock = 1'b1;
        wait_run("t6_relock");

        // Reset from RUN restores the init values
        reset = 1'b1;
        tick();
        chk("mr_ps", {28'd0, psda}, 32'h0);
        chk("mr_du", {28'd0, dutyda}, 32'h8);
        chk("mr_loss", {24'd0, loss_cnt}, 32'h0);
        chk("mr_pll", {31'd0, pll_reset}, 32'd1);
        chk("mr_sys", {31'd0, sys_rst_out}, 32'd1);
        chk("mr_lkd", {31'd0, locked}, 32'd0);

        // Test 3: one-cycle lock glitch in STABLE restarts the count.
        // lock_s is low after edge 11, seen at edge 12 (back to WAIT_LOCK),
        // STABLE again at 13, 8 more edges -> release at edge 21.
        reset = 1'b0;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (n == 9) pll_lock = 1'b0;
            if (n == 10) pll_lock = 1'b1;
            if (!sys_rst_out) break;
        end
        chk("t3_lat", n, 32'd21);

        // Test 2: no lock -> 4 high / 20 low retry pattern
        reset    = 1'b1;
        pll_lock = 1'b0;
        tick();
        reset    = 1'b0;
        seen_low = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (!sys_rst_out) seen_low = 1'b1;
            case (i)
                3:  chk("t2_e3", {31'd0, pll_reset}, 32'd1);
                4:  chk("t2_e4", {31'd0, pll_reset}, 32'd0);
                23: chk("t2_e23", {31'd0, pll_reset}, 32'd0);
                24: chk("t2_e24", {31'd0, pll_reset}, 32'd1);
                27: chk("t2_e27", {31'd0, pll_reset}, 32'd1);
                28: chk("t2_e28", {31'd0, pll_reset}, 32'd0);
                47: chk("t2_e47", {31'd0, pll_reset}, 32'd0);
                48: chk("t2_e48", {31'd0, pll_reset_p}, 32'd1);
                default: ;
            endcase
        end
        chk("t2_sys", {31'd0, seen_low}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
